// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial bit-pattern transmitter
// Latches a parallel word and shifts out its low len bits MSB-first, with optional gapped repeats.
module seq_pattern_tx #(
  parameter int DATA_W = 8,
  parameter int REP_W  = 4,
  parameter int GAP    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [$clog2(DATA_W+1)-1:0] in_len,
  input  logic [REP_W-1:0]            in_rep,
  input  logic                        abort,
  output logic                        dout,
  output logic                        dout_valid,
  output logic                        busy,
  output logic                        done
);
  localparam int LW = $clog2(DATA_W+1);
  localparam int GW = $clog2(GAP+2);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t            state, state_n;
  logic              dout_n, valid_n, done_n;
  logic [DATA_W-1:0] pat, pat_n, sh, sh_n, aligned;
  logic [LW-1:0]     len_q, len_n, cnt, cnt_n, len_eff;
  logic [REP_W-1:0]  rep, rep_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic              accept;

  // The field is left-aligned so every bit leaves from the MSB of a plain shifter.
  assign len_eff  = (in_len == '0 || in_len > LW'(DATA_W)) ? LW'(DATA_W) : in_len;
  assign aligned  = in_data << (LW'(DATA_W) - len_eff);
  assign in_ready = reset || (state == S_IDLE && !abort);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_n = state;
    dout_n  = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    pat_n   = pat;
    sh_n    = sh;
    len_n   = len_q;
    cnt_n   = cnt;
    rep_n   = rep;
    gcnt_n  = gcnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          pat_n   = aligned;
          sh_n    = aligned << 1;
          dout_n  = aligned[DATA_W-1];
          valid_n = 1'b1;
          len_n   = len_eff;
          cnt_n   = len_eff - LW'(1);
          rep_n   = in_rep;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          rep_n   = '0;
          gcnt_n  = '0;
        end else if (cnt != '0) begin
          dout_n  = sh[DATA_W-1];
          sh_n    = sh << 1;
          cnt_n   = cnt - LW'(1);
          valid_n = 1'b1;
        end else if (rep != '0) begin
          rep_n = rep - REP_W'(1);
          if (GAP == 0) begin
            dout_n  = pat[DATA_W-1];
            sh_n    = pat << 1;
            cnt_n   = len_q - LW'(1);
            valid_n = 1'b1;
          end else begin
            gcnt_n  = GW'(GAP - 1);
            state_n = S_GAP;
          end
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          rep_n   = '0;
          gcnt_n  = '0;
        end else if (gcnt == '0) begin
          dout_n  = pat[DATA_W-1];
          sh_n    = pat << 1;
          cnt_n   = len_q - LW'(1);
          valid_n = 1'b1;
          state_n = S_SEND;
        end else begin
          gcnt_n = gcnt - GW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      pat        <= '0;
      sh         <= '0;
      len_q      <= '0;
      cnt        <= '0;
      rep        <= '0;
      gcnt       <= '0;
    end else begin
      state      <= state_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      done       <= done_n;
      pat        <= pat_n;
      sh         <= sh_n;
      len_q      <= len_n;
      cnt        <= cnt_n;
      rep        <= rep_n;
      gcnt       <= gcnt_n;
    end
  end
endmodule
